mem_csr_ctrl: RTL and testbench
===============================

Name: mem_csr_ctrl

Overview:
- Parametrised successor to the single-port CSR-gated memory.
- Provides a word-addressed memory plus a CSR block behind one valid/ready request channel and one valid/ready response channel.
- Adds byte strobes, error responses, saturating read/write/drop counters, a scratch register, and back-pressure.
- Sits between a bus master (driver or bridge) and the memory array; it is the target of the register model.

Parameters:
ADDR_WIDTH, 8, word-address width
DATA_WIDTH, 32, data width; multiple of 8, at least 16
MEM_SIZE, 16, memory depth in words; mapped at addresses 0..MEM_SIZE-1; MEM_SIZE must be less than or equal to CSR_BASE
CSR_BASE, 'h20, word address of the first CSR

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset, sampled on posedge clk
req_valid  in  1  request present
req_ready  out  1  block can accept a request
wr  in  1  1 = write, 0 = read; qualified by req_valid
addr  in  ADDR_WIDTH  word address
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables for writes
rsp_valid  out  1  response present
rsp_ready  in  1  master accepts response
rdata  out  DATA_WIDTH  read data; 0 for writes and for errored accesses
rsp_err  out  1  access error flag, qualified by rsp_valid

Behaviour:
- Reset (synchronous, active-high, on posedge clk with reset=1):
  - req_ready=0, rsp_valid=0, rdata=0, rsp_err=0.
  - All memory words, counters, CTRL and SCRATCH cleared to 0.
  - FSM goes to IDLE.
  - Reset overrides any in-flight request or pending response; that response is lost.
- FSM states: IDLE, RESP.
  - IDLE: req_ready=1. On req_valid && req_ready, the access executes at that clock edge and the FSM moves to RESP.
  - RESP: req_ready=0. rsp_valid=1, with rdata and rsp_err held stable. On rsp_ready, return to IDLE.
  - Latency: the response is visible exactly 1 cycle after acceptance.
  - One access is outstanding at a time, so maximum throughput is 1 access per 2 cycles when rsp_ready is held high.
- CSR map (word addresses):
  - CSR_BASE+0 WR_COUNT: read-only; successful memory writes.
  - CSR_BASE+1 RD_COUNT: read-only; successful memory reads.
  - CSR_BASE+2 CTRL: read/write; bit0 CHIP_EN; bits [DATA_WIDTH-1:1] read as 0 and ignore writes.
  - CSR_BASE+3 SCRATCH: read/write; full width.
  - CSR_BASE+4 DROPPED: counts errored accesses; a write of any value clears it to 0, with rsp_err=0.
- Memory access (addr < MEM_SIZE):
  - Allowed only when CTRL.CHIP_EN=1.
  - Write: each byte lane is updated only where its wstrb bit is 1. WR_COUNT increments even when wstrb=0.
  - Read: returns the word and increments RD_COUNT.
- Error cases (rsp_err=1, rdata=0, no state change, DROPPED increments):
  - Memory access while CHIP_EN=0.
  - Unmapped address (MEM_SIZE <= addr < CSR_BASE, or addr > CSR_BASE+4).
  - Write to WR_COUNT or RD_COUNT.
- CSR access ignores CHIP_EN. CTRL and SCRATCH writes honour wstrb.
- Counters are DATA_WIDTH wide and saturate at all-ones; they never wrap.
- Address wrap is not used: the address is never truncated, so an address of MEM_SIZE or above never aliases into memory.
- Inputs are sampled only on the accepting edge. Changes to req inputs while in RESP are ignored.

Test Plan:
- Reset, then read CTRL, WR_COUNT and DROPPED -> each returns 0, rsp_err=0, response 1 cycle after acceptance.
- With CHIP_EN=0, write addr 3 data 'hDEADBEEF -> rsp_err=1, DROPPED=1, then read of addr 3 errors and DROPPED=2. Write CTRL=1, write addr 3 again, read addr 3 -> 'hDEADBEEF, WR_COUNT=1, RD_COUNT=1.
- With CHIP_EN=1 and mem[5]='h11223344, write 'hAABBCCDD with wstrb='b0101 -> read of addr 5 returns 'h11BB33DD.
- Write to addr 'h10 (unmapped), then write to WR_COUNT -> both rsp_err=1, DROPPED=2, WR_COUNT unchanged. Then write DROPPED -> DROPPED=0.
- Hold rsp_ready=0 for 5 cycles after a read of SCRATCH='h5A5A5A5A -> rsp_valid and rdata stay stable, req_ready=0, and a new req_valid is ignored until the handshake completes.
- Assert reset while in RESP -> next cycle rsp_valid=0 and req_ready=0; after reset, memory and all counters read 0.

Source files
------------

// File: rtl/mem_csr_ctrl_if.sv
// Request/response channel between a bus master and mem_csr_ctrl.
// One valid/ready request path and one valid/ready response path.
interface mem_csr_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    wr;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, wr, addr, wdata, wstrb, rsp_ready,
        input  req_ready, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  req_valid, wr, addr, wdata, wstrb, rsp_ready,
        output req_ready, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/mem_csr_ctrl.sv
// Word-addressed memory plus CSR block behind one request/response channel.
// One access outstanding at a time; response is registered and held until
// the master takes it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; the access executes on the accepting edge
// RESP  | response held on rsp_valid/rdata/rsp_err until rsp_ready
module mem_csr_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 16,
    parameter int CSR_BASE   = 'h20
) (
    input  logic           clk,
    input  logic           reset,
    mem_csr_ctrl_if.slave  bus
);
    localparam int          NUM_BYTES = DATA_WIDTH / 8;
    localparam int          IDX_W     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [31:0] MEM_TOP   = 32'(MEM_SIZE);
    localparam logic [31:0] CSR_LO    = 32'(CSR_BASE);
    localparam logic [31:0] CSR_HI    = 32'(CSR_BASE) + 32'd4;

    typedef enum logic [0:0] {IDLE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
    logic [DATA_WIDTH-1:0] mem_d [MEM_SIZE];
    logic [DATA_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [DATA_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [DATA_WIDTH-1:0] dropped_q, dropped_d;
    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic                  chip_en_q, chip_en_d;

    logic [31:0]           addr_w;
    logic [31:0]           csr_off;
    logic [IDX_W-1:0]      mem_idx;
    logic                  acc_err;

    // Full address is kept so nothing at or above MEM_SIZE aliases into memory.
    assign addr_w  = 32'(bus.addr);
    assign csr_off = addr_w - CSR_LO;
    assign mem_idx = addr_w[IDX_W-1:0];

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rdata     = rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [NUM_BYTES-1:0]  strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // Next state, access decode and register updates.
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        mem_d     = mem_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        dropped_d = dropped_q;
        scratch_d = scratch_q;
        chip_en_d = chip_en_q;
        acc_err   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d = RESP;
                    rdata_d = '0;
                    if (addr_w < MEM_TOP) begin
                        if (!chip_en_q) begin
                            acc_err = 1'b1;
                        end else if (bus.wr) begin
                            mem_d[mem_idx] = merge(mem_q[mem_idx], bus.wdata, bus.wstrb);
                            wr_cnt_d       = sat_inc(wr_cnt_q);
                        end else begin
                            rdata_d  = mem_q[mem_idx];
                            rd_cnt_d = sat_inc(rd_cnt_q);
                        end
                    end else if (addr_w >= CSR_LO && addr_w <= CSR_HI) begin
                        case (csr_off)
                            32'd0: if (bus.wr) acc_err = 1'b1; else rdata_d = wr_cnt_q;
                            32'd1: if (bus.wr) acc_err = 1'b1; else rdata_d = rd_cnt_q;
                            32'd2: begin
                                if (bus.wr) begin
                                    if (bus.wstrb[0]) chip_en_d = bus.wdata[0];
                                end else begin
                                    rdata_d = {{(DATA_WIDTH-1){1'b0}}, chip_en_q};
                                end
                            end
                            32'd3: begin
                                if (bus.wr) scratch_d = merge(scratch_q, bus.wdata, bus.wstrb);
                                else        rdata_d   = scratch_q;
                            end
                            default: begin
                                if (bus.wr) dropped_d = '0;
                                else        rdata_d   = dropped_q;
                            end
                        endcase
                    end else begin
                        acc_err = 1'b1;
                    end
                    if (acc_err) begin
                        rdata_d   = '0;
                        dropped_d = sat_inc(dropped_q);
                    end
                    rsp_err_d = acc_err;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State, response and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            dropped_q   <= '0;
            scratch_q   <= '0;
            chip_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_q       <= mem_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            dropped_q   <= dropped_d;
            scratch_q   <= scratch_d;
            chip_en_q   <= chip_en_d;
        end
    end
endmodule

// File: tb/tb_mem_csr_ctrl.sv
// Directed bench for mem_csr_ctrl with a response scoreboard.
module tb_mem_csr_ctrl;
    localparam logic [7:0] A_WRC  = 8'h20;
    localparam logic [7:0] A_RDC  = 8'h21;
    localparam logic [7:0] A_CTRL = 8'h22;
    localparam logic [7:0] A_SCR  = 8'h23;
    localparam logic [7:0] A_DROP = 8'h24;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    mem_csr_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    mem_csr_ctrl #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .MEM_SIZE(16),
        .CSR_BASE('h20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: push expectation, wait for acceptance, pop and compare the
    // response one cycle later, optionally holding rsp_ready low for hold cycles
    // while an intruding write to addr 3 is presented.
    task automatic access(input string tag, input bit w, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] er, input bit ee, input int hold);
        exp_t e;
        int   n;
        exp_q.push_back('{err: ee, rdata: er});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.wr        = w;
        bus.addr      = a;
        bus.wdata     = d;
        bus.wstrb     = s;
        bus.rsp_ready = (hold == 0);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.wr        = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.wstrb     = '0;
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, "_rdata"}, bus.rdata, e.rdata);
        check({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
        if (hold > 0) begin
            bus.req_valid = 1'b1;
            bus.wr        = 1'b1;
            bus.addr      = 8'h03;
            bus.wdata     = 32'h0;
            bus.wstrb     = 4'hF;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            check({tag, "_hold_rdata"}, bus.rdata, e.rdata);
            check({tag, "_hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.wr        = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.wstrb     = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_rsp_done"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.wr        = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.wstrb     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        reset = 1'b0;

        access("rd_ctrl0", 0, A_CTRL, 0, 0, 32'h0, 0, 0);
        access("rd_wrc0", 0, A_WRC, 0, 0, 32'h0, 0, 0);
        access("rd_drop0", 0, A_DROP, 0, 0, 32'h0, 0, 0);

        access("wr_mem_dis", 1, 8'h03, 32'hDEADBEEF, 4'hF, 32'h0, 1, 0);
        access("rd_drop1", 0, A_DROP, 0, 0, 32'h1, 0, 0);
        access("rd_mem_dis", 0, 8'h03, 0, 0, 32'h0, 1, 0);
        access("rd_drop2", 0, A_DROP, 0, 0, 32'h2, 0, 0);
        access("wr_ctrl1", 1, A_CTRL, 32'h1, 4'hF, 32'h0, 0, 0);
        access("wr_mem3", 1, 8'h03, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);
        access("rd_mem3", 0, 8'h03, 0, 0, 32'hDEADBEEF, 0, 0);
        access("rd_wrc1", 0, A_WRC, 0, 0, 32'h1, 0, 0);
        access("rd_rdc1", 0, A_RDC, 0, 0, 32'h1, 0, 0);

        access("wr_mem5", 1, 8'h05, 32'h11223344, 4'hF, 32'h0, 0, 0);
        access("wr_mem5_strb", 1, 8'h05, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0);
        access("wr_mem5_nostrb", 1, 8'h05, 32'hFFFFFFFF, 4'b0000, 32'h0, 0, 0);
        access("rd_mem5", 0, 8'h05, 0, 0, 32'h11BB33DD, 0, 0);
        access("rd_wrc4", 0, A_WRC, 0, 0, 32'h4, 0, 0);

        access("clr_drop_a", 1, A_DROP, 32'h1234, 4'h0, 32'h0, 0, 0);
        access("rd_drop_clr_a", 0, A_DROP, 0, 0, 32'h0, 0, 0);
        access("wr_unmapped", 1, 8'h10, 32'h55, 4'hF, 32'h0, 1, 0);
        access("wr_wrc", 1, A_WRC, 32'h99, 4'hF, 32'h0, 1, 0);
        access("rd_drop_2b", 0, A_DROP, 0, 0, 32'h2, 0, 0);
        access("rd_wrc_same", 0, A_WRC, 0, 0, 32'h4, 0, 0);
        access("rd_above_csr", 0, 8'h25, 0, 0, 32'h0, 1, 0);
        access("wr_rdc", 1, A_RDC, 32'h7, 4'hF, 32'h0, 1, 0);
        access("rd_drop_4", 0, A_DROP, 0, 0, 32'h4, 0, 0);
        access("clr_drop_b", 1, A_DROP, 32'hFFFFFFFF, 4'hF, 32'h0, 0, 0);
        access("rd_drop_clr_b", 0, A_DROP, 0, 0, 32'h0, 0, 0);

        access("wr_mem15", 1, 8'h0F, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0);
        access("rd_mem15", 0, 8'h0F, 0, 0, 32'hCAFEF00D, 0, 0);
        access("rd_mem0", 0, 8'h00, 0, 0, 32'h0, 0, 0);

        access("wr_scr", 1, A_SCR, 32'h5A5A5A5A, 4'hF, 32'h0, 0, 0);
        access("rd_scr_hold", 0, A_SCR, 0, 0, 32'h5A5A5A5A, 0, 5);
        access("rd_mem3_after_hold", 0, 8'h03, 0, 0, 32'hDEADBEEF, 0, 0);
        access("wr_scr_strb", 1, A_SCR, 32'h12345678, 4'b1000, 32'h0, 0, 0);
        access("rd_scr_strb", 0, A_SCR, 0, 0, 32'h125A5A5A, 0, 0);
        access("wr_ctrl_nostrb", 1, A_CTRL, 32'h0, 4'h0, 32'h0, 0, 0);
        access("rd_ctrl_still1", 0, A_CTRL, 0, 0, 32'h1, 0, 0);
        access("wr_ctrl_hi", 1, A_CTRL, 32'hFFFFFFFE, 4'hF, 32'h0, 0, 0);
        access("rd_ctrl_hi", 0, A_CTRL, 0, 0, 32'h0, 0, 0);
        access("rd_mem_off", 0, 8'h03, 0, 0, 32'h0, 1, 0);
        access("wr_ctrl_on", 1, A_CTRL, 32'h1, 4'hF, 32'h0, 0, 0);

        // Reset while a response is pending: the response is dropped.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.wr        = 1'b0;
        bus.addr      = 8'h03;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.addr      = '0;
        @(negedge clk);
        check("pre_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;

        access("post_rst_rd_ctrl", 0, A_CTRL, 0, 0, 32'h0, 0, 0);
        access("post_rst_rd_rdc", 0, A_RDC, 0, 0, 32'h0, 0, 0);
        access("post_rst_rd_wrc", 0, A_WRC, 0, 0, 32'h0, 0, 0);
        access("post_rst_rd_drop", 0, A_DROP, 0, 0, 32'h0, 0, 0);
        access("post_rst_rd_scr", 0, A_SCR, 0, 0, 32'h0, 0, 0);
        access("post_rst_en", 1, A_CTRL, 32'h1, 4'hF, 32'h0, 0, 0);
        access("post_rst_rd_mem3", 0, 8'h03, 0, 0, 32'h0, 0, 0);
        access("post_rst_rd_mem5", 0, 8'h05, 0, 0, 32'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
